// File: rtl/hazard_forward_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit_pkg
// Shared definitions for the hazard/forwarding unit and the datapath muxes that
// decode its selects.
//   - Forward-select encoding: FWD_RF (0) selects the register file. A nonzero
//     select names a result bus. For ID consumers, j+1 means the bus of stage j.
//     For EXE consumers, j means the bus of stage j.
//   - Tag layout (TW = AW+2 bits): {wen, dest[AW-1:0], is_load}.
// -----------------------------------------------------------------------------
package hazard_forward_unit_pkg;

   localparam int unsigned FWD_RF       = 0;
   localparam int unsigned TAG_LOAD_BIT = 0;
   localparam int unsigned TAG_DEST_LSB = 1;

   // Tag width for a given register-number width.
   function automatic int unsigned tag_w(input int unsigned aw);
      return aw + 2;
   endfunction

   // Bit position of the write-enable flag inside a tag.
   function automatic int unsigned tag_wen_bit(input int unsigned aw);
      return aw + 1;
   endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit_if
// ID-stage view of the hazard unit.
//   master : pipeline control. It drives the ID instruction description, flush
//            and ext_hold, and receives stall, the forward selects and stall_cnt.
//   slave  : the hazard unit.
// id_src packs port p at [p*AW +: AW]. The forward selects pack port p at
// [p*SELW +: SELW].
// -----------------------------------------------------------------------------
interface hazard_forward_unit_if #(
   parameter int AW    = 5,
   parameter int NRP   = 2,
   parameter int DEPTH = 3,
   parameter int CNTW  = 32
);
   localparam int SELW = $clog2(DEPTH + 1);

   logic                 id_valid;
   logic [NRP*AW-1:0]    id_src;
   logic [NRP-1:0]       id_src_used;
   logic                 id_is_branch;
   logic [AW-1:0]        id_dest;
   logic                 id_wen;
   logic                 id_is_load;
   logic                 flush;
   logic                 ext_hold;
   logic                 stall;
   logic [NRP*SELW-1:0]  fwd_sel_id;
   logic [NRP*SELW-1:0]  fwd_sel_exe;
   logic [CNTW-1:0]      stall_cnt;

   modport master (
      output id_valid, id_src, id_src_used, id_is_branch, id_dest, id_wen,
             id_is_load, flush, ext_hold,
      input  stall, fwd_sel_id, fwd_sel_exe, stall_cnt
   );

   modport slave (
      input  id_valid, id_src, id_src_used, id_is_branch, id_dest, id_wen,
             id_is_load, flush, ext_hold,
      output stall, fwd_sel_id, fwd_sel_exe, stall_cnt
   );

endinterface

// File: rtl/hazard_forward_unit_fwd_match_port.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit_fwd_match_port
// Priority match of one source register against all tracked stage tags.
//   src/used : source register number and whether the port is read
//   tags     : DEPTH packed tags, stage k at [k*TW +: TW] (stage 0 = EXE)
//   hit      : some stage writes src (register 0 never matches)
//   idx      : youngest (lowest-index) matching stage
//   is_load  : that producer is a load
// -----------------------------------------------------------------------------
module hazard_forward_unit_fwd_match_port
   import hazard_forward_unit_pkg::*;
#(
   parameter int AW    = 5,
   parameter int DEPTH = 3,
   parameter int IDXW  = 2
) (
   input  logic [AW-1:0]                 src,
   input  logic                          used,
   input  logic [DEPTH*tag_w(AW)-1:0]    tags,
   output logic                          hit,
   output logic [IDXW-1:0]               idx,
   output logic                          is_load
);
   localparam int TW = tag_w(AW);
   localparam int WB = tag_wen_bit(AW);

   // Walk from oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      hit     = 1'b0;
      idx     = '0;
      is_load = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (used && (src != '0) && tags[k*TW + WB] &&
             (tags[k*TW + TAG_DEST_LSB +: AW] == src)) begin
            hit     = 1'b1;
            idx     = IDXW'(k);
            is_load = tags[k*TW + TAG_LOAD_BIT];
         end
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
// Hazard control for the in-order MIPS pipeline. It tracks destination tags for
// stages EXE..WB, produces forward selects for ID (branch compare) and EXE
// consumers, detects load-use and branch-use hazards, stalls and bubbles, and
// counts stall cycles with saturation.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   hif        : slave side of hazard_forward_unit_if (ID instruction, flush,
//                ext_hold in; stall, fwd_sel_id, fwd_sel_exe, stall_cnt out)
// -----------------------------------------------------------------------------
module hazard_forward_unit
   import hazard_forward_unit_pkg::*;
#(
   parameter int AW         = 5,
   parameter int DEPTH      = 3,
   parameter int NRP        = 2,
   parameter int LOAD_STAGE = 2,
   parameter int CNTW       = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   hazard_forward_unit_if.slave  hif
);
   localparam int SELW = $clog2(DEPTH + 1);
   localparam int TW   = tag_w(AW);
   localparam int WB   = tag_wen_bit(AW);

   logic [DEPTH*TW-1:0]   tags_q, tags_d;
   logic [NRP*SELW-1:0]   fwd_sel_exe_q, fwd_sel_exe_d;
   logic [CNTW-1:0]       stall_cnt_q, stall_cnt_d;

   logic [NRP-1:0]        hit, hit_load, haz;
   logic [SELW-1:0]       idx [NRP];
   logic [NRP*SELW-1:0]   fwd_sel_id_c;
   logic [TW-1:0]         id_tag;
   logic                  stall_c, issue;

   for (genvar p = 0; p < NRP; p++) begin : g_port
      hazard_forward_unit_fwd_match_port #(
         .AW    (AW),
         .DEPTH (DEPTH),
         .IDXW  (SELW)
      ) u_match (
         .src     (hif.id_src[p*AW +: AW]),
         .used    (hif.id_src_used[p]),
         .tags    (tags_q),
         .hit     (hit[p]),
         .idx     (idx[p]),
         .is_load (hit_load[p])
      );
   end

   // Hazard detection and ID forward selects from the current tags.
   always_comb begin
      fwd_sel_id_c = '0;
      haz          = '0;
      for (int p = 0; p < NRP; p++) begin
         if (hit[p]) begin
            fwd_sel_id_c[p*SELW +: SELW] = idx[p] + SELW'(1);
            if (hif.id_is_branch) begin
               // Branch compares in ID; an ALU result is only on a bus from MEM on.
               haz[p] = hit_load[p] ? (int'(idx[p]) < LOAD_STAGE)
                                    : (int'(idx[p]) < 1);
            end else begin
               // EXE consumer sees the producer one stage further along.
               haz[p] = hit_load[p] && (int'(idx[p]) + 1 < LOAD_STAGE);
            end
         end
      end
      stall_c = hif.id_valid & ~hif.flush & (|haz);
      issue   = hif.id_valid & ~hif.flush & ~stall_c;
      id_tag                         = '0;
      id_tag[WB]                     = hif.id_wen;
      id_tag[TAG_DEST_LSB +: AW]     = hif.id_dest;
      id_tag[TAG_LOAD_BIT]           = hif.id_is_load;
   end

   // Next state: shift tags, register EXE selects, count stalls.
   always_comb begin
      tags_d        = tags_q;
      fwd_sel_exe_d = fwd_sel_exe_q;
      stall_cnt_d   = stall_cnt_q;
      if (!hif.ext_hold) begin
         for (int k = DEPTH - 1; k >= 1; k--) begin
            tags_d[k*TW +: TW] = tags_q[(k-1)*TW +: TW];
         end
         tags_d[0 +: TW] = issue ? id_tag : '0;

         // After the shift the producer sits one stage older; a producer leaving
         // the last stage is already in the register file.
         fwd_sel_exe_d = '0;
         if (issue) begin
            for (int p = 0; p < NRP; p++) begin
               if (hit[p] && (int'(idx[p]) + 1 <= DEPTH - 1)) begin
                  fwd_sel_exe_d[p*SELW +: SELW] = idx[p] + SELW'(1);
               end
            end
         end

         if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tags_q        <= '0;
         fwd_sel_exe_q <= '0;
         stall_cnt_q   <= '0;
      end else begin
         tags_q        <= tags_d;
         fwd_sel_exe_q <= fwd_sel_exe_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign hif.stall       = stall_c;
   assign hif.fwd_sel_id  = fwd_sel_id_c;
   assign hif.fwd_sel_exe = fwd_sel_exe_q;
   assign hif.stall_cnt   = stall_cnt_q;

endmodule
